// File: rtl/msi_bus_controller_pkg.sv
// Shared types for the two-core snooping coherence bus: cache line states,
// bus FSM states, request kinds and fill-source encodings.
package msi_bus_controller_pkg;

  typedef enum logic [1:0] {
    INVALID  = 2'b00,
    SHARED   = 2'b01,
    MODIFIED = 2'b10
  } blk_state_t;

  typedef enum logic [2:0] {
    BUS_IDLE     = 3'd0,
    BUS_SNOOP    = 3'd1,
    BUS_INVAL    = 3'd2,
    BUS_WAIT_MEM = 3'd3,
    BUS_RESPOND  = 3'd4
  } bus_state_t;

  typedef enum logic [1:0] {
    REQ_RD  = 2'b00,
    REQ_WR  = 2'b01,
    REQ_INV = 2'b10
  } req_type_t;

  localparam logic [1:0] SOURCE_DMEM       = 2'b00;
  localparam logic [1:0] SOURCE_OTHER_PROC = 2'b01;

  // A snoop only counts as a hit when the peer holds the line in a live state.
  function automatic logic snoop_hit(input logic found, input logic [1:0] state);
    return found && (blk_state_t'(state) != INVALID);
  endfunction

endpackage

// File: rtl/msi_bus_controller_slot.sv
// One pending-request slot per CPU: captures a request pulse, resolves
// simultaneous pulses (WR > RD > INV) and flags dropped or conflicting pulses.
module bus_req_slot
  import msi_bus_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_miss,
  input  logic        write_miss,
  input  logic        invalidate,
  input  logic [12:0] addr,
  input  logic        clear,
  output logic        valid,
  output logic [1:0]  req_type,
  output logic [12:0] req_addr,
  output logic        err
);

  logic      any_pulse;
  logic      multi_pulse;
  logic      busy;
  logic      accept;
  req_type_t pick;

  // A slot being cleared this cycle is free, so a pulse landing on RESPOND is kept.
  always_comb begin
    any_pulse   = read_miss | write_miss | invalidate;
    multi_pulse = (read_miss & write_miss) | (read_miss & invalidate) |
                  (write_miss & invalidate);
    busy        = valid & ~clear;
    accept      = any_pulse & ~busy;
    err         = any_pulse & (busy | multi_pulse);
    if (write_miss)     pick = REQ_WR;
    else if (read_miss) pick = REQ_RD;
    else                pick = REQ_INV;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (accept) begin
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  // Payload is only looked at while valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_type <= pick;
      req_addr <= addr;
    end
  end

endmodule

// File: rtl/msi_bus_controller.sv
// Snooping coherence bus for the two-core SMP: round-robin arbitration of
// per-CPU miss/upgrade requests, peer snoop, invalidation and fill routing.
module msi_bus_controller
  import msi_bus_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       read_miss,
  input  logic [1:0]       write_miss,
  input  logic [1:0]       invalidate,
  input  logic [1:0][12:0] bico,
  input  logic [1:0]       cpu_search_found,
  input  logic [1:0][1:0]  block_state,
  input  logic [1:0][15:0] send_other_proc_data,
  input  logic             u_rdy,
  output logic [1:0]       grant,
  output logic [1:0]       cpu_search,
  output logic [1:0][12:0] boci,
  output logic [1:0][15:0] other_proc_data,
  output logic [1:0][1:0]  cpu_datasel,
  output logic [1:0]       invalidate_from_other_cpu,
  output logic             proto_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  bus_state_t       state;
  logic             owner;
  logic             last_owner;
  logic             src_peer;
  req_type_t        cur_type;
  logic [12:0]      cur_addr;
  logic [CNT_W-1:0] mem_cnt;

  logic [1:0]       slot_valid;
  logic [1:0]       slot_err;
  logic [1:0]       slot_clear;
  logic [1:0][1:0]  slot_type;
  logic [1:0][12:0] slot_addr;

  logic             next_owner;
  logic             peer;
  logic             peer_hit;
  logic             mem_expired;

  for (genvar g = 0; g < 2; g++) begin : g_slot
    bus_req_slot u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .read_miss  (read_miss[g]),
      .write_miss (write_miss[g]),
      .invalidate (invalidate[g]),
      .addr       (bico[g]),
      .clear      (slot_clear[g]),
      .valid      (slot_valid[g]),
      .req_type   (slot_type[g]),
      .req_addr   (slot_addr[g]),
      .err        (slot_err[g])
    );
  end

  always_comb begin
    peer        = ~owner;
    peer_hit    = snoop_hit(cpu_search_found[peer], block_state[peer]);
    next_owner  = (&slot_valid) ? ~last_owner : slot_valid[1];
    mem_expired = (mem_cnt == CNT_W'(MEM_TIMEOUT));
    slot_clear  = 2'b00;
    if (state == BUS_RESPOND || (state == BUS_INVAL && cur_type == REQ_INV)) begin
      slot_clear[owner] = 1'b1;
    end
  end

  // Transaction payload is latched when IDLE selects an owner.
  always_ff @(posedge clk) begin
    if (state == BUS_IDLE && |slot_valid) begin
      cur_type <= req_type_t'(slot_type[next_owner]);
      cur_addr <= slot_addr[next_owner];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                     <= BUS_IDLE;
      owner                     <= 1'b0;
      last_owner                <= 1'b1;
      src_peer                  <= 1'b0;
      mem_cnt                   <= '0;
      grant                     <= 2'b00;
      cpu_search                <= 2'b00;
      boci                      <= '0;
      other_proc_data           <= '0;
      cpu_datasel               <= {SOURCE_DMEM, SOURCE_DMEM};
      invalidate_from_other_cpu <= 2'b00;
      proto_err                 <= 1'b0;
    end else begin
      grant                     <= 2'b00;
      cpu_search                <= 2'b00;
      invalidate_from_other_cpu <= 2'b00;
      proto_err                 <= |slot_err;

      case (state)
        BUS_IDLE: begin
          if (|slot_valid) begin
            owner             <= next_owner;
            boci[~next_owner] <= slot_addr[next_owner];
            if (req_type_t'(slot_type[next_owner]) == REQ_INV) begin
              invalidate_from_other_cpu[~next_owner] <= 1'b1;
              state <= BUS_INVAL;
            end else begin
              cpu_search[~next_owner] <= 1'b1;
              state <= BUS_SNOOP;
            end
          end
        end

        // Peer answers combinationally while cpu_search is high.
        BUS_SNOOP: begin
          src_peer               <= peer_hit;
          cpu_datasel[owner]     <= peer_hit ? SOURCE_OTHER_PROC : SOURCE_DMEM;
          other_proc_data[owner] <= peer_hit ? send_other_proc_data[peer] : 16'h0000;
          if (cur_type == REQ_WR) begin
            invalidate_from_other_cpu[peer] <= 1'b1;
            boci[peer] <= cur_addr;
            state      <= BUS_INVAL;
          end else if (peer_hit) begin
            grant[owner] <= 1'b1;
            state        <= BUS_RESPOND;
          end else begin
            mem_cnt <= '0;
            state   <= BUS_WAIT_MEM;
          end
        end

        BUS_INVAL: begin
          if (cur_type == REQ_INV) begin
            state <= BUS_IDLE;
          end else if (src_peer) begin
            grant[owner] <= 1'b1;
            state        <= BUS_RESPOND;
          end else begin
            mem_cnt <= '0;
            state   <= BUS_WAIT_MEM;
          end
        end

        // A stuck memory still completes the miss so the requester never hangs.
        BUS_WAIT_MEM: begin
          if (u_rdy) begin
            grant[owner] <= 1'b1;
            state        <= BUS_RESPOND;
          end else if (mem_expired) begin
            grant[owner] <= 1'b1;
            proto_err    <= 1'b1;
            state        <= BUS_RESPOND;
          end else begin
            mem_cnt <= mem_cnt + 1'b1;
          end
        end

        BUS_RESPOND: begin
          last_owner <= owner;
          state      <= BUS_IDLE;
        end

        default: state <= BUS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msi_bus_controller.sv
// Scoreboard bench for msi_bus_controller: directed requests push expected bus
// events; a negedge monitor pops and compares every strobe the DUT raises.
module tb_msi_bus_controller;
  import msi_bus_controller_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       read_miss, write_miss, invalidate;
  logic [1:0][12:0] bico;
  logic [1:0]       cpu_search_found;
  logic [1:0][1:0]  block_state;
  logic [1:0][15:0] send_other_proc_data;
  logic             u_rdy;
  logic [1:0]       grant, cpu_search, invalidate_from_other_cpu;
  logic [1:0][12:0] boci;
  logic [1:0][15:0] other_proc_data;
  logic [1:0][1:0]  cpu_datasel;
  logic             proto_err;

  msi_bus_controller dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .read_miss                 (read_miss),
    .write_miss                (write_miss),
    .invalidate                (invalidate),
    .bico                      (bico),
    .cpu_search_found          (cpu_search_found),
    .block_state               (block_state),
    .send_other_proc_data      (send_other_proc_data),
    .u_rdy                     (u_rdy),
    .grant                     (grant),
    .cpu_search                (cpu_search),
    .boci                      (boci),
    .other_proc_data           (other_proc_data),
    .cpu_datasel               (cpu_datasel),
    .invalidate_from_other_cpu (invalidate_from_other_cpu),
    .proto_err                 (proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_SEARCH = 0, K_INVAL = 1, K_GRANT = 2, K_PERR = 3;

  typedef struct {
    int         cyc;
    int         kind;
    int         cpu;
    logic [15:0] val;
    logic [1:0]  sel;
    bit          chk_v;
    bit          chk_s;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  p;

  function automatic string kname(int k);
    case (k)
      K_SEARCH: return "cpu_search";
      K_INVAL:  return "invalidate";
      K_GRANT:  return "grant";
      default:  return "proto_err";
    endcase
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(int c, int k, int cpu, logic [15:0] v, logic [1:0] s,
                           bit cv, bit cs);
    ev_t e;
    e.cyc = c; e.kind = k; e.cpu = cpu; e.val = v; e.sel = s;
    e.chk_v = cv; e.chk_s = cs;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(int k, int cpu, logic [15:0] v, logic [1:0] s);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected %s cpu%0d at cyc %0d (val=%h sel=%0d), required none",
               kname(k), cpu, cyc, v, s);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cpu != cpu || e.cyc != cyc ||
          (e.chk_v && e.val !== v) || (e.chk_s && e.sel !== s)) begin
        bad++;
        $display("FAIL %s: got %s cpu%0d cyc=%0d val=%h sel=%0d, required %s cpu%0d cyc=%0d val=%h sel=%0d",
                 kname(e.kind), kname(k), cpu, cyc, v, s,
                 kname(e.kind), e.cpu, e.cyc, e.val, e.sel);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++)
        if (cpu_search[i]) check_ev(K_SEARCH, i, {3'b000, boci[i]}, 2'b00);
      for (int i = 0; i < 2; i++)
        if (invalidate_from_other_cpu[i]) check_ev(K_INVAL, i, {3'b000, boci[i]}, 2'b00);
      for (int i = 0; i < 2; i++)
        if (grant[i]) check_ev(K_GRANT, i, other_proc_data[i], cpu_datasel[i]);
      if (proto_err) check_ev(K_PERR, 0, 16'h0000, 2'b00);
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic check_outputs_idle(string tag);
    chk({tag, "_grant"},     {30'd0, grant}, 32'd0);
    chk({tag, "_search"},    {30'd0, cpu_search}, 32'd0);
    chk({tag, "_inval"},     {30'd0, invalidate_from_other_cpu}, 32'd0);
    chk({tag, "_proto_err"}, {31'd0, proto_err}, 32'd0);
    chk({tag, "_boci"},      {6'd0, boci}, 32'd0);
    chk({tag, "_opd"},       other_proc_data, 32'd0);
    chk({tag, "_datasel"},   {28'd0, cpu_datasel}, 32'd0);
  endtask

  task automatic drain(int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      tick(1);
      n++;
    end
    tick(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse(logic [1:0] rd, logic [1:0] wr, logic [1:0] inv,
                       logic [12:0] a0, logic [12:0] a1);
    read_miss  = rd;
    write_miss = wr;
    invalidate = inv;
    bico[0]    = a0;
    bico[1]    = a1;
    tick(1);
    read_miss  = 2'b00;
    write_miss = 2'b00;
    invalidate = 2'b00;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    read_miss = '0; write_miss = '0; invalidate = '0; bico = '0;
    cpu_search_found = '0; block_state = '0; send_other_proc_data = '0;
    u_rdy = 1'b0;
    tick(3);
    check_outputs_idle("reset");
    rst_n = 1'b1;
    tick(2);
    check_outputs_idle("post_reset");

    // CPU0 read, peer hit SHARED
    cpu_search_found = 2'b10;
    block_state[1] = SHARED;
    send_other_proc_data[1] = 16'hBEEF;
    p = cyc;
    expect_ev(p + 2, K_SEARCH, 1, 16'h0042, 2'b00, 1, 0);
    expect_ev(p + 3, K_GRANT, 0, 16'hBEEF, SOURCE_OTHER_PROC, 1, 1);
    pulse(2'b01, 2'b00, 2'b00, 13'h0042, 13'h0000);
    drain(20);

    // CPU1 write, peer miss, memory ready after 5 wait cycles
    cpu_search_found = 2'b00;
    p = cyc;
    expect_ev(p + 2,  K_SEARCH, 0, 16'h1003, 2'b00, 1, 0);
    expect_ev(p + 3,  K_INVAL,  0, 16'h1003, 2'b00, 1, 0);
    expect_ev(p + 10, K_GRANT,  1, 16'h0000, SOURCE_DMEM, 0, 1);
    pulse(2'b00, 2'b10, 2'b00, 13'h0000, 13'h1003);
    tick(8);
    u_rdy = 1'b1;
    tick(1);
    u_rdy = 1'b0;
    drain(20);

    // Both read together; CPU0 re-requests on its RESPOND cycle
    cpu_search_found = 2'b11;
    block_state = {SHARED, SHARED};
    send_other_proc_data[0] = 16'h1111;
    send_other_proc_data[1] = 16'h2222;
    p = cyc;
    expect_ev(p + 2, K_SEARCH, 1, 16'h0100, 2'b00, 1, 0);
    expect_ev(p + 3, K_GRANT,  0, 16'h2222, SOURCE_OTHER_PROC, 1, 1);
    expect_ev(p + 5, K_SEARCH, 0, 16'h0200, 2'b00, 1, 0);
    expect_ev(p + 6, K_GRANT,  1, 16'h1111, SOURCE_OTHER_PROC, 1, 1);
    expect_ev(p + 8, K_SEARCH, 1, 16'h0300, 2'b00, 1, 0);
    expect_ev(p + 9, K_GRANT,  0, 16'h2222, SOURCE_OTHER_PROC, 1, 1);
    pulse(2'b11, 2'b00, 2'b00, 13'h0100, 13'h0200);
    tick(2);
    pulse(2'b01, 2'b00, 2'b00, 13'h0300, 13'h0000);
    drain(30);

    // Both again: CPU0 served last, so CPU1 wins
    p = cyc;
    expect_ev(p + 2, K_SEARCH, 0, 16'h0400, 2'b00, 1, 0);
    expect_ev(p + 3, K_GRANT,  1, 16'h1111, SOURCE_OTHER_PROC, 1, 1);
    expect_ev(p + 5, K_SEARCH, 1, 16'h0500, 2'b00, 1, 0);
    expect_ev(p + 6, K_GRANT,  0, 16'h2222, SOURCE_OTHER_PROC, 1, 1);
    pulse(2'b11, 2'b00, 2'b00, 13'h0500, 13'h0400);
    drain(30);

    // CPU0 upgrade: invalidate only, no grant, fill source untouched
    p = cyc;
    expect_ev(p + 2, K_INVAL, 1, 16'h0010, 2'b00, 1, 0);
    pulse(2'b00, 2'b00, 2'b01, 13'h0010, 13'h0000);
    drain(20);
    chk("inv_keeps_datasel0", {30'd0, cpu_datasel[0]}, {30'd0, SOURCE_OTHER_PROC});

    // CPU1 read+write in one cycle -> write wins, peer MODIFIED hit
    cpu_search_found = 2'b01;
    block_state[0] = MODIFIED;
    send_other_proc_data[0] = 16'hCAFE;
    p = cyc;
    expect_ev(p + 1, K_PERR,   0, 16'h0000, 2'b00, 0, 0);
    expect_ev(p + 2, K_SEARCH, 0, 16'h0ABC, 2'b00, 1, 0);
    expect_ev(p + 3, K_INVAL,  0, 16'h0ABC, 2'b00, 1, 0);
    expect_ev(p + 4, K_GRANT,  1, 16'hCAFE, SOURCE_OTHER_PROC, 1, 1);
    pulse(2'b10, 2'b10, 2'b00, 13'h0000, 13'h0ABC);
    drain(20);

    // Memory timeout plus a dropped second request
    cpu_search_found = 2'b00;
    p = cyc;
    expect_ev(p + 2,   K_SEARCH, 1, 16'h0777, 2'b00, 1, 0);
    expect_ev(p + 11,  K_PERR,   0, 16'h0000, 2'b00, 0, 0);
    expect_ev(p + 259, K_GRANT,  0, 16'h0000, SOURCE_DMEM, 0, 1);
    expect_ev(p + 259, K_PERR,   0, 16'h0000, 2'b00, 0, 0);
    pulse(2'b01, 2'b00, 2'b00, 13'h0777, 13'h0000);
    tick(9);
    pulse(2'b01, 2'b00, 2'b00, 13'h0555, 13'h0000);
    drain(400);

    // Reset while waiting on memory aborts everything
    p = cyc;
    expect_ev(p + 2, K_SEARCH, 0, 16'h0123, 2'b00, 1, 0);
    pulse(2'b10, 2'b00, 2'b00, 13'h0000, 13'h0123);
    tick(4);
    rst_n = 1'b0;
    #1;
    check_outputs_idle("midreset");
    tick(2);
    rst_n = 1'b1;
    tick(20);
    drain(1);
    check_outputs_idle("after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msi_bus_controller.md
# msi_bus_controller

Snooping coherence bus for the two-core SMP: collects miss/invalidate requests from both `cache_controller` instances, arbitrates round-robin, snoops the peer cache, and routes fill data from either peer cache or data memory. It is the responder end of the `read_miss`/`write_miss`/`invalidate`/`BICO` interface and the driver of `grant`, `cpu_search`, `BOCI`, `other_proc_data`, `cpu_datasel` and `invalidate_from_other_cpu`.

## Interface
- `MEM_TIMEOUT`, 255: max WAIT_MEM cycles before forced completion.
- `clk  input  1`: single clock, rising edge.
- `rst_n  input  1`: asynchronous, active-low reset.
- `read_miss  input  [1:0]`: one-cycle request pulse per CPU (index = CPU id).
- `write_miss  input  [1:0]`: one-cycle request pulse per CPU.
- `invalidate  input  [1:0]`: one-cycle upgrade (S→M) pulse per CPU.
- `bico  input  [1:0][12:0]`: requester word address, valid with the pulse.
- `cpu_search_found  input  [1:0]`: snoop hit from each cache.
- `block_state  input  [1:0][1:0]`: snooped `blk_state_t` from each cache.
- `send_other_proc_data  input  [1:0][15:0]`: snooped word from each cache.
- `u_rdy  input  1`: data memory ready.
- `grant  output  [1:0]`: one-cycle completion to requester.
- `cpu_search  output  [1:0]`: snoop strobe to peer cache.
- `boci  output  [1:0][12:0]`: snoop/invalidate address to each cache.
- `other_proc_data  output  [1:0][15:0]`: forwarded peer word.
- `cpu_datasel  output  [1:0][1:0]`: fill source per CPU (SOURCE_DMEM / SOURCE_OTHER_PROC).
- `invalidate_from_other_cpu  output  [1:0]`: invalidate strobe to a cache.
- `proto_err  output  1`: one-cycle pulse on dropped request or memory timeout.

## Operation
- Per CPU one pending slot: type (RD/WR/INV) + 13-bit address, captured at the edge after a pulse. Pulse while slot already full → dropped, `proto_err`. More than one of the three pulses in the same cycle from one CPU → priority WR > RD > INV, `proto_err`.
- States: IDLE, SNOOP, INVAL, WAIT_MEM, RESPOND.
- IDLE: if any slot pending, pick owner; both pending → CPU not in `last_owner` wins. Latch owner, `peer = ~owner`. INV type → INVAL; else → SNOOP.
- SNOOP (1 cycle): `cpu_search[peer]=1`, `boci[peer]=addr`. Sample peer. `found && state!=INVALID` → capture `send_other_proc_data[peer]`, datasel=SOURCE_OTHER_PROC; else datasel=SOURCE_DMEM. Next: WR → INVAL; RD & peer source → RESPOND; RD & DMEM → WAIT_MEM.
- INVAL (1 cycle): `invalidate_from_other_cpu[peer]=1`, `boci[peer]=addr`. Next: INV type → IDLE (slot cleared, no grant); WR & peer source → RESPOND; WR & DMEM → WAIT_MEM.
- WAIT_MEM: counter from 0; `u_rdy` → RESPOND; counter reaching `MEM_TIMEOUT` → RESPOND with `proto_err`.
- RESPOND (1 cycle): `grant[owner]=1`, `cpu_datasel[owner]` and `other_proc_data[owner]` driven from latched values; clear owner slot; `last_owner<=owner`; → IDLE.
- `cpu_datasel` and `other_proc_data` hold from SNOOP exit until the next SNOOP for that CPU (controller reads them across its miss state). `boci` holds its last value; it is only meaningful with a strobe.
- Addresses are compared nowhere; same-line races are serialized by arbitration order.

## Timing
- Reset: state IDLE, slots empty, `last_owner=1` (CPU0 wins first tie), counter 0; all outputs 0 (`cpu_datasel`=SOURCE_DMEM).
- Pulse in cycle 0 → slot valid cycle 1 → SNOOP cycle 2 → RESPOND cycle 3 (peer hit, RD) ⇒ `grant` 3 cycles after pulse. WR peer hit: 4. INV: strobe in cycle 2.
- DMEM path: RESPOND is the cycle after `u_rdy` sampled high in WAIT_MEM.
- Pulse arriving in the same cycle its CPU's slot is cleared (RESPOND) is accepted.
- Reset mid-transaction: all aborts immediately; no grant issued.

## Structure
- `common` package: existing `blk_state_t`; add `bus_state_t`, `req_type_t`, `SOURCE_DMEM=2'b00`, `SOURCE_OTHER_PROC=2'b01`.
- Optional sub-module `bus_req_slot` (one per CPU): capture, priority, overflow detect.

## Test plan
- CPU0 `read_miss` addr 13'h0042, peer `found=1`, state SHARED, data 16'hBEEF → `cpu_search[1]` cycle 2, `grant[0]` cycle 3, `cpu_datasel[0]=01`, `other_proc_data[0]=16'hBEEF`.
- CPU1 `write_miss` 13'h1003, peer miss, `u_rdy` high after 5 WAIT_MEM cycles → `invalidate_from_other_cpu[0]` once, `cpu_datasel[1]=00`, single `grant[1]`.
- Both `read_miss` same cycle → CPU0 granted first, CPU1 next; repeat → CPU1 then CPU0.
- CPU0 `invalidate` 13'h0010 → `invalidate_from_other_cpu[1]` with `boci[1]=13'h0010` cycle 2, no `grant`.
- `u_rdy` never asserts → `grant` + `proto_err` after `MEM_TIMEOUT`+1 WAIT_MEM cycles; second pulse while pending → `proto_err`, no extra grant.
- `rst_n` low during WAIT_MEM → all outputs 0, no grant after release.
